// File: rtl/multi_pulse_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_pulse_generator_pkg
// Purpose  : Shared types and default constants for the multi-channel pulse
//            train generator. Holds the per-channel FSM state encoding and
//            the default parameter values used by the top and channel blocks.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multi_pulse_generator_pkg;

  // Per-channel train sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } ch_state_t;

  // Default parameter values
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RPT_W       = 8;
  localparam int DEF_RESET_DELAY = 8;

endpackage : multi_pulse_generator_pkg
`default_nettype wire

// File: rtl/multi_pulse_generator_pulse_channel.sv
`default_nettype none
// ============================================================================
// Module   : pulse_channel
// Purpose  : One pulse-train channel: IDLE -> DELAY -> ACTIVE -> (GAP ->
//            ACTIVE)* -> IDLE. Timing configuration is captured at start so
//            later changes on the shared cfg_* bus do not disturb a running
//            train. Zero-valued settings behave as 1.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-low reset
//            ready      - block-level start enable
//            start      - start request for this channel
//            abort      - return to IDLE on the next edge, no done strobe
//            cfg_delay  - cycles from start sample to first rise
//            cfg_width  - pulse high cycles
//            cfg_gap    - low cycles between pulses
//            cfg_repeat - pulses per train
//            pulse_out  - registered pulse output
//            busy       - channel not IDLE
//            done       - one-cycle strobe at the edge the last pulse falls
// Revision : 1.0 - initial release
// ============================================================================
module pulse_channel
  import multi_pulse_generator_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int RPT_W = DEF_RPT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [RPT_W-1:0] cfg_repeat,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  ch_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [RPT_W-1:0] rpt, rpt_nx;
  logic [CNT_W-1:0] width, width_nx;
  logic [CNT_W-1:0] gap, gap_nx;
  logic             pulse, pulse_nx;
  logic             done_q, done_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rpt    <= '0;
      width  <= '0;
      gap    <= '0;
      pulse  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rpt    <= rpt_nx;
      width  <= width_nx;
      gap    <= gap_nx;
      pulse  <= pulse_nx;
      done_q <= done_nx;
    end
  end

  // The counter holds the number of edges left in the current phase; the
  // phase ends on the edge where it reads 1, so a loaded value N gives
  // exactly N cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rpt_nx   = rpt;
    width_nx = width;
    gap_nx   = gap;
    pulse_nx = pulse;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        // A start coinciding with the done strobe is dropped so trains
        // cannot be chained back-to-back by holding start high.
        if (ready && start && !done_q) begin
          state_nx = DELAY;
          cnt_nx   = (cfg_delay  == '0) ? CNT_W'(1) : cfg_delay;
          width_nx = (cfg_width  == '0) ? CNT_W'(1) : cfg_width;
          gap_nx   = (cfg_gap    == '0) ? CNT_W'(1) : cfg_gap;
          rpt_nx   = (cfg_repeat == '0) ? RPT_W'(1) : cfg_repeat;
        end
      end
      DELAY: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ACTIVE;
          pulse_nx = 1'b1;
          cnt_nx   = width;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt == CNT_W'(1)) begin
          pulse_nx = 1'b0;
          if (rpt == RPT_W'(1)) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            cnt_nx   = '0;
            rpt_nx   = '0;
          end else begin
            state_nx = GAP;
            cnt_nx   = gap;
            rpt_nx   = rpt - RPT_W'(1);
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ACTIVE;
          pulse_nx = 1'b1;
          cnt_nx   = width;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        pulse_nx = 1'b0;
        cnt_nx   = '0;
        rpt_nx   = '0;
      end
    endcase

    // Abort overrides normal sequencing and suppresses the done strobe
    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
      pulse_nx = 1'b0;
      done_nx  = 1'b0;
      cnt_nx   = '0;
      rpt_nx   = '0;
    end
  end

  assign pulse_out = pulse;
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule : pulse_channel
`default_nettype wire

// File: rtl/multi_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module   : multi_pulse_generator
// Purpose  : NUM_CH independent pulse-train channels sharing one timing
//            configuration bus. Holds the reset synchroniser and the
//            post-reset ready delay; each channel is a pulse_channel.
//            Optional feature macro: MULTI_PULSE_GEN_ABORT_EN adds the
//            per-channel abort input.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-low reset
//            start      - per-channel start request
//            abort      - per-channel abort (MULTI_PULSE_GEN_ABORT_EN only)
//            cfg_delay  - cycles from start sample to first pulse rise
//            cfg_width  - pulse high cycles
//            cfg_gap    - low cycles between pulses
//            cfg_repeat - pulses per train
//            pulse_out  - registered pulse outputs
//            busy       - channel not IDLE
//            done       - one-cycle strobe at train end
//            ready      - block accepting starts
// Revision : 1.0 - initial release
// ============================================================================
module multi_pulse_generator
  import multi_pulse_generator_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RPT_W       = DEF_RPT_W,
  parameter int RESET_DELAY = DEF_RESET_DELAY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] start,
`ifdef MULTI_PULSE_GEN_ABORT_EN
  input  logic [NUM_CH-1:0] abort,
`endif
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [RPT_W-1:0]  cfg_repeat,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic              ready
);

  // Reset synchroniser: assertion is immediate, release takes two edges.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  // ready rises on edge RESET_DELAY after release, counting the two
  // synchroniser edges. The synchroniser alone needs two edges, so values
  // below 2 behave as 2.
  if (RESET_DELAY <= 2) begin : g_ready_short
    assign ready = rst_n_int;
  end else begin : g_ready_count
    localparam int RD_W = $clog2(RESET_DELAY);

    logic [RD_W-1:0] dly_cnt;
    logic            ready_q;

    // Counting starts on edge 3; ready is set on the edge where the count
    // already seen equals RESET_DELAY-3.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dly_cnt <= '0;
        ready_q <= 1'b0;
      end else if (rst_n_int && !ready_q) begin
        dly_cnt <= dly_cnt + RD_W'(1);
        if (dly_cnt == RD_W'(RESET_DELAY - 3)) begin
          ready_q <= 1'b1;
        end
      end
    end

    assign ready = ready_q;
  end

  logic [NUM_CH-1:0] abort_int;

`ifdef MULTI_PULSE_GEN_ABORT_EN
  assign abort_int = abort;
`else
  assign abort_int = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_channel #(
      .CNT_W (CNT_W),
      .RPT_W (RPT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (rst_n_int),
      .ready      (ready),
      .start      (start[i]),
      .abort      (abort_int[i]),
      .cfg_delay  (cfg_delay),
      .cfg_width  (cfg_width),
      .cfg_gap    (cfg_gap),
      .cfg_repeat (cfg_repeat),
      .pulse_out  (pulse_out[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule : multi_pulse_generator
`default_nettype wire

// File: tb/tb_multi_pulse_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multi_pulse_generator
// Purpose  : Directed self-checking bench for multi_pulse_generator.
//            Define MULTI_PULSE_GEN_ABORT_EN to include the abort scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_pulse_generator;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int RPT_W       = 8;
  localparam int RESET_DELAY = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] start;
`ifdef MULTI_PULSE_GEN_ABORT_EN
  logic [NUM_CH-1:0] abort;
`endif
  logic [CNT_W-1:0]  cfg_delay;
  logic [CNT_W-1:0]  cfg_width;
  logic [CNT_W-1:0]  cfg_gap;
  logic [RPT_W-1:0]  cfg_repeat;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic              ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_pulse_generator #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .RPT_W       (RPT_W),
    .RESET_DELAY (RESET_DELAY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef MULTI_PULSE_GEN_ABORT_EN
    .abort      (abort),
`endif
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_repeat (cfg_repeat),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .ready      (ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pulse level j edges after the start-sampling edge
  function automatic logic model_pulse(int j, int d, int w, int g, int r);
    int n;
    int m;
    if (j < d) return 1'b0;
    n = (j - d) / (w + g);
    m = (j - d) % (w + g);
    return (n < r) && (m < w);
  endfunction

  task automatic test_reset();
    reset      = 1'b0;
    start      = '1;
    cfg_delay  = '0;
    cfg_width  = '0;
    cfg_gap    = '0;
    cfg_repeat = '0;
`ifdef MULTI_PULSE_GEN_ABORT_EN
    abort      = '0;
`endif
    repeat (3) step();
    checks++;
    if (pulse_out !== '0 || busy !== '0 || done !== '0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pulse=%b busy=%b done=%b ready=%b, required all zero", pulse_out, busy, done, ready);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= RESET_DELAY + 2; n++) begin
      if (n == RESET_DELAY) start = '0;
      step();
      checks++;
      if (ready !== (n >= RESET_DELAY)) begin
        failures++;
        $display("FAIL ready_delay edge %0d: ready=%b required=%b", n, ready, (n >= RESET_DELAY));
      end
      checks++;
      if (busy !== '0 || pulse_out !== '0) begin
        failures++;
        $display("FAIL start_before_ready edge %0d: busy=%b pulse=%b required 0", n, busy, pulse_out);
      end
    end
  endtask

  task automatic test_single_train();
    logic [NUM_CH-1:0] ep, ed, eb;
    cfg_delay  = 16'd3;
    cfg_width  = 16'd5;
    cfg_gap    = 16'd2;
    cfg_repeat = 8'd3;
    start      = 4'b0001;
    step();
    start = '0;
    for (int j = 0; j <= 25; j++) begin
      if (j > 0) step();
      ep = '0; ed = '0; eb = '0;
      ep[0] = model_pulse(j, 3, 5, 2, 3);
      ed[0] = (j == 22);
      eb[0] = (j < 22);
      checks++;
      if (pulse_out !== ep || done !== ed || busy !== eb) begin
        failures++;
        $display("FAIL single_train j=%0d: pulse=%b done=%b busy=%b required pulse=%b done=%b busy=%b", j, pulse_out, done, busy, ep, ed, eb);
      end
    end
  endtask

  task automatic test_zero_cfg();
    logic [NUM_CH-1:0] ep, ed, eb;
    cfg_delay  = '0;
    cfg_width  = '0;
    cfg_gap    = '0;
    cfg_repeat = '0;
    start      = 4'b1111;
    step();
    start = '0;
    for (int j = 0; j <= 3; j++) begin
      if (j > 0) step();
      ep = (j == 1) ? 4'b1111 : 4'b0000;
      ed = (j == 2) ? 4'b1111 : 4'b0000;
      eb = (j < 2)  ? 4'b1111 : 4'b0000;
      checks++;
      if (pulse_out !== ep || done !== ed || busy !== eb) begin
        failures++;
        $display("FAIL zero_cfg j=%0d: pulse=%b done=%b busy=%b required pulse=%b done=%b busy=%b", j, pulse_out, done, busy, ep, ed, eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_CH-1:0] ep, ed, eb;
    cfg_delay  = 16'd2;
    cfg_width  = 16'd3;
    cfg_gap    = 16'd1;
    cfg_repeat = 8'd2;
    start      = 4'b0010;
    step();
    start = '0;
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) begin
        start = (j == 3 || j == 4 || j == 9 || j == 10) ? 4'b0010 : 4'b0000;
        if (j == 1) cfg_width = 16'd7;
        step();
      end
      ep = '0; ed = '0; eb = '0;
      ep[1] = model_pulse(j, 2, 3, 1, 2);
      ed[1] = (j == 9);
      eb[1] = (j < 9);
      checks++;
      if (pulse_out !== ep || done !== ed || busy !== eb) begin
        failures++;
        $display("FAIL back_to_back j=%0d: pulse=%b done=%b busy=%b required pulse=%b done=%b busy=%b", j, pulse_out, done, busy, ep, ed, eb);
      end
    end
    start = '0;
  endtask

  task automatic test_reset_mid_train();
    cfg_delay  = 16'd1;
    cfg_width  = 16'd10;
    cfg_gap    = 16'd1;
    cfg_repeat = 8'd1;
    start      = 4'b0001;
    step();
    start = '0;
    repeat (3) step();
    checks++;
    if (pulse_out !== 4'b0001) begin
      failures++;
      $display("FAIL mid_train_active: pulse=%b required 0001", pulse_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (pulse_out !== '0 || busy !== '0 || done !== '0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: pulse=%b busy=%b done=%b ready=%b required all zero", pulse_out, busy, done, ready);
    end
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= RESET_DELAY + 1; n++) begin
      step();
      checks++;
      if (ready !== (n >= RESET_DELAY) || done !== '0 || pulse_out !== '0) begin
        failures++;
        $display("FAIL reset_redelay edge %0d: ready=%b done=%b pulse=%b required ready=%b done=0 pulse=0", n, ready, done, pulse_out, (n >= RESET_DELAY));
      end
    end
  endtask

`ifdef MULTI_PULSE_GEN_ABORT_EN
  task automatic test_abort();
    logic [NUM_CH-1:0] ep, ed, eb;
    cfg_delay  = 16'd1;
    cfg_width  = 16'd2;
    cfg_gap    = 16'd3;
    cfg_repeat = 8'd2;
    start      = 4'b1100;
    step();
    start = '0;
    for (int j = 1; j <= 10; j++) begin
      abort = (j == 4) ? 4'b0100 : 4'b0000;
      step();
      ep = '0; ed = '0; eb = '0;
      ep[3] = model_pulse(j, 1, 2, 3, 2);
      ed[3] = (j == 8);
      eb[3] = (j < 8);
      if (j < 4) begin
        ep[2] = model_pulse(j, 1, 2, 3, 2);
        eb[2] = 1'b1;
      end
      checks++;
      if (pulse_out !== ep || done !== ed || busy !== eb) begin
        failures++;
        $display("FAIL abort j=%0d: pulse=%b done=%b busy=%b required pulse=%b done=%b busy=%b", j, pulse_out, done, busy, ep, ed, eb);
      end
    end
    abort = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_train();
    test_zero_cfg();
    test_back_to_back();
    test_reset_mid_train();
`ifdef MULTI_PULSE_GEN_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multi_pulse_generator
`default_nettype wire
